// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator control core.
package calc_pkg;
    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        REQ     = 2'd2,
        SHOW    = 2'd3
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Single BCD digit increment, wraps 9 -> 0 with no carry out.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction
endpackage

// File: rtl/calc_digit_editor.sv
// Slider-driven BCD edit register: lowest active slider wins, auto-repeat every STEP_TICKS.
module calc_digit_editor
    import calc_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STEP_TICKS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DIGITS-1:0]       sld,
    input  logic                    en,
    input  logic                    clr,
    output logic [BCD_W*DIGITS-1:0] edit_inc,
    output logic [BCD_W*DIGITS-1:0] edit_nxt
);
    localparam int CNT_W = $clog2(STEP_TICKS + 1);
    localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [BCD_W*DIGITS-1:0] edit;
    logic                    any, prev_any, inc;
    logic [SEL_W-1:0]        sel, prev_sel;
    logic [CNT_W-1:0]        cnt, cnt_d;

    always_comb begin
        any = 1'b0;
        sel = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (en && sld[i]) begin
                any = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

    // A fresh selection increments at once; a held one repeats when cnt reaches STEP_TICKS.
    always_comb begin
        inc   = 1'b0;
        cnt_d = '0;
        if (any) begin
            if (!prev_any || sel != prev_sel || cnt == CNT_W'(STEP_TICKS)) begin
                inc   = 1'b1;
                cnt_d = CNT_W'(1);
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign edit_inc[g*BCD_W +: BCD_W] = (inc && sel == SEL_W'(g)) ?
            bcd_inc(edit[g*BCD_W +: BCD_W]) : edit[g*BCD_W +: BCD_W];
    end

    assign edit_nxt = clr ? '0 : edit_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edit     <= '0;
            prev_any <= 1'b0;
            prev_sel <= '0;
            cnt      <= '0;
        end else begin
            edit     <= edit_nxt;
            prev_any <= any;
            prev_sel <= sel;
            cnt      <= cnt_d;
        end
    end
endmodule

// File: rtl/calc_sequencer.sv
// Calculator control core: operand entry FSM, ALU req/ack handshake and display source select.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STEP_TICKS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_clr,
    input  logic                    btn_ent,
    input  logic [DIGITS-1:0]       sld,
    input  logic                    arith_sel,
    output logic                    alu_req,
    output logic                    alu_op,
    output logic [BCD_W*DIGITS-1:0] alu_a,
    output logic [BCD_W*DIGITS-1:0] alu_b,
    input  logic                    alu_ack,
    input  logic [BCD_W*DIGITS-1:0] alu_result,
    input  logic                    alu_neg,
    input  logic                    alu_ovf,
    output logic [BCD_W*DIGITS-1:0] disp_value,
    output logic                    disp_neg,
    output logic                    disp_err,
    output logic [1:0]              phase
);
    localparam int W = BCD_W * DIGITS;

    state_t         state, state_d;
    op_t            op, op_d;
    logic [W-1:0]   a_d, b_d, res, res_d, edit_inc, edit_nxt, disp_value_d;
    logic           neg, neg_d, ovf, ovf_d, pend, pend_d, req_d;
    logic           edit_clr, clr_all, disp_neg_d, disp_err_d;

    calc_digit_editor #(.DIGITS(DIGITS), .STEP_TICKS(STEP_TICKS)) u_edit (
        .clk      (clk),
        .reset    (reset),
        .sld      (sld),
        .en       (state == ENTER_A || state == ENTER_B),
        .clr      (edit_clr),
        .edit_inc (edit_inc),
        .edit_nxt (edit_nxt)
    );

    always_comb begin
        state_d  = state;
        op_d     = op;
        a_d      = alu_a;
        b_d      = alu_b;
        res_d    = res;
        neg_d    = neg;
        ovf_d    = ovf;
        pend_d   = pend;
        req_d    = alu_req;
        edit_clr = 1'b0;
        clr_all  = 1'b0;
        case (state)
            ENTER_A: begin
                if (btn_clr) clr_all = 1'b1;
                else if (btn_ent) begin
                    a_d      = edit_inc;
                    edit_clr = 1'b1;
                    state_d  = ENTER_B;
                end
            end
            ENTER_B: begin
                if (btn_clr) clr_all = 1'b1;
                else if (btn_ent) begin
                    b_d      = edit_inc;
                    edit_clr = 1'b1;
                    op_d     = op_t'(arith_sel);
                    req_d    = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // Clear never withdraws an outstanding request; it is deferred past the ack.
                if (btn_clr) pend_d = 1'b1;
                if (alu_req && alu_ack) begin
                    res_d = alu_result;
                    neg_d = alu_neg;
                    ovf_d = alu_ovf;
                    req_d = 1'b0;
                    if (pend_d) clr_all = 1'b1;
                    else        state_d = SHOW;
                end
            end
            SHOW: begin
                if (btn_clr) clr_all = 1'b1;
                else if (op != op_t'(arith_sel)) begin
                    op_d    = op_t'(arith_sel);
                    req_d   = 1'b1;
                    state_d = REQ;
                end else if (btn_ent) begin
                    edit_clr = 1'b1;
                    state_d  = ENTER_A;
                end
            end
            default: state_d = ENTER_A;
        endcase
        if (clr_all) begin
            state_d  = ENTER_A;
            a_d      = '0;
            b_d      = '0;
            res_d    = '0;
            neg_d    = 1'b0;
            ovf_d    = 1'b0;
            pend_d   = 1'b0;
            edit_clr = 1'b1;
        end
    end

    // Display is selected from next-state values so the registered outputs track state changes.
    always_comb begin
        disp_value_d = edit_nxt;
        case (state_d)
            REQ:     disp_value_d = b_d;
            SHOW:    disp_value_d = res_d;
            default: disp_value_d = edit_nxt;
        endcase
        disp_neg_d = (state_d == SHOW) && neg_d;
        disp_err_d = (state_d == SHOW) && ovf_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ENTER_A;
            op         <= OP_ADD;
            alu_a      <= '0;
            alu_b      <= '0;
            res        <= '0;
            neg        <= 1'b0;
            ovf        <= 1'b0;
            pend       <= 1'b0;
            alu_req    <= 1'b0;
            disp_value <= '0;
            disp_neg   <= 1'b0;
            disp_err   <= 1'b0;
        end else begin
            state      <= state_d;
            op         <= op_d;
            alu_a      <= a_d;
            alu_b      <= b_d;
            res        <= res_d;
            neg        <= neg_d;
            ovf        <= ovf_d;
            pend       <= pend_d;
            alu_req    <= req_d;
            disp_value <= disp_value_d;
            disp_neg   <= disp_neg_d;
            disp_err   <= disp_err_d;
        end
    end

    assign alu_op = op;
    assign phase  = state;
endmodule
